ram_sp_be_clr: RTL and testbench

Parametrised single-port synchronous RAM, the successor of the fixed 8x8 RAM. Adds configurable width and depth, byte-write enables, and a registered read with a valid strobe. Also adds a hardware clear engine that zeroes the array after reset or on request, with a busy flag. It is a general storage block for the memory subsystem, sitting behind simple wr/rd controllers.

---
 rtl/ram_pkg.sv | 18 +
 rtl/ram_clear_ctrl.sv | 49 ++++
 rtl/ram_sp_be_clr.sv | 88 ++++++++
 tb/tb_ram_sp_be_clr.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the single-port byte-enable RAM with clear engine:
// state encoding and the address-width helper.
package ram_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_CLEAR = 1'b1;

    // Ceiling log2, never below 1 so a one-word RAM still has an address bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Clear engine: walks the array one word per cycle writing zeros, after reset
// (when INIT_CLEAR) or on a clr pulse while idle.
module ram_clear_ctrl
    import ram_pkg::*;
#(
    parameter int  DEPTH      = 8,
    parameter bit  INIT_CLEAR = 1'b1,
    localparam int AW         = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic          state;
    logic [AW-1:0] cnt;

    // Reset mid-clear lands here too, so the walk restarts from word 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            state <= INIT_CLEAR ? ST_CLEAR : ST_IDLE;
            busy  <= INIT_CLEAR;
        end else if (state == ST_IDLE) begin
            if (clr) begin
                state <= ST_CLEAR;
                busy  <= 1'b1;
                cnt   <= '0;
            end
        end else begin
            if (cnt == LAST) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign clr_we   = (state == ST_CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/ram_sp_be_clr.sv
// Single-port synchronous RAM with byte enables, registered read-first output
// and a hardware clear engine that owns the write port while busy.
module ram_sp_be_clr
    import ram_pkg::*;
#(
    parameter int  DW         = 8,
    parameter int  DEPTH      = 8,
    parameter bit  INIT_CLEAR = 1'b1,
    localparam int AW         = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic             rd,
    input  logic [AW-1:0]    add,
    input  logic [DW-1:0]    data_in,
    input  logic [DW/8-1:0]  be,
    input  logic             clr,
    output logic [DW-1:0]    data_out,
    output logic             rd_valid,
    output logic             busy
);

    localparam int NB = DW / 8;

    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          acc_en;
    logic          add_ok;

    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [NB-1:0] wbe;

    logic [DW-1:0] mem [DEPTH];

    ram_clear_ctrl #(
        .DEPTH      (DEPTH),
        .INIT_CLEAR (INIT_CLEAR)
    ) u_clr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A clr pulse takes priority over any access presented the same cycle.
    assign acc_en = !busy && !clr;
    assign add_ok = ({1'b0, add} < (AW + 1)'(DEPTH));

    always_comb begin
        we    = 1'b0;
        waddr = add;
        wdata = data_in;
        wbe   = be;
        if (clr_we) begin
            we    = 1'b1;
            waddr = clr_addr;
            wdata = '0;
            wbe   = '1;
        end else begin
            we = wr && acc_en && add_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && we) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read-first: sees the word as it was before a same-edge write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd && acc_en;
            if (rd && acc_en) data_out <= add_ok ? mem[add] : '0;
        end
    end

endmodule

// File: tb/tb_ram_sp_be_clr.sv
// Scoreboard bench for ram_sp_be_clr (DW=16, DEPTH=6): directed scenarios then
// random traffic, checked against a word-array reference model.
module tb_ram_sp_be_clr;

    localparam int DW    = 16;
    localparam int DEPTH = 6;
    localparam int AW    = 3;
    localparam int NB    = DW / 8;

    logic          clk;
    logic          rst_n;
    logic          wr;
    logic          rd;
    logic [AW-1:0] add;
    logic [DW-1:0] data_in;
    logic [NB-1:0] be;
    logic          clr;
    logic [DW-1:0] data_out;
    logic          rd_valid;
    logic          busy;

    ram_sp_be_clr #(
        .DW         (DW),
        .DEPTH      (DEPTH),
        .INIT_CLEAR (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr       (wr),
        .rd       (rd),
        .add      (add),
        .data_in  (data_in),
        .be       (be),
        .clr      (clr),
        .data_out (data_out),
        .rd_valid (rd_valid),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] ref_mem [DEPTH];
    int            busy_left;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] last_dout;
    int            n_vec;
    int            n_err;
    bit            mon_en;

    // Drive one cycle of inputs, then advance the reference model across the edge.
    task automatic step(input logic r_n, input logic w, input logic r, input logic c,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [NB-1:0] b);
        @(negedge clk);
        rst_n = r_n; wr = w; rd = r; clr = c; add = a; data_in = d; be = b;
        @(posedge clk);
        if (!r_n) begin
            busy_left = DEPTH;
            exp_q.delete();
            last_dout = '0;
        end else if (busy_left > 0) begin
            ref_mem[DEPTH - busy_left] = '0;
            busy_left--;
        end else if (c) begin
            busy_left = DEPTH;
        end else begin
            if (r) exp_q.push_back((int'(a) < DEPTH) ? ref_mem[a] : '0);
            if (w && int'(a) < DEPTH) begin
                for (int i = 0; i < NB; i++)
                    if (b[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
            end
        end
        mon_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic wr_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] b);
        step(1'b1, 1'b1, 1'b0, 1'b0, a, d, b);
    endtask

    task automatic rd_word(input logic [AW-1:0] a);
        step(1'b1, 1'b0, 1'b1, 1'b0, a, '0, '0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            n_vec++;
            if (busy !== (busy_left > 0)) begin
                n_err++;
                $display("FAIL busy: got %b want %b at %0t", busy, (busy_left > 0), $time);
            end
            if (rd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_rd_valid: got 1 want 0 at %0t", $time);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    n_vec++;
                    if (data_out !== e) begin
                        n_err++;
                        $display("FAIL read_data: got %h want %h at %0t", data_out, e, $time);
                    end
                    last_dout = e;
                end
            end else begin
                if (exp_q.size() > 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL missing_rd_valid: got %b want 1 at %0t", rd_valid, $time);
                    exp_q.delete();
                end
                n_vec++;
                if (data_out !== last_dout) begin
                    n_err++;
                    $display("FAIL data_hold: got %h want %h at %0t", data_out, last_dout, $time);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; wr = 1'b0; rd = 1'b0; clr = 1'b0;
        add = '0; data_in = '0; be = '0;
        n_vec = 0; n_err = 0; mon_en = 1'b0;
        busy_left = 0; last_dout = '0;

        // Reset, init clear, every word (and out-of-range addresses) reads zero.
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        idle(DEPTH + 1);
        for (int i = 0; i < 8; i++) rd_word(AW'(i));
        idle(1);

        // Byte-enable merge.
        wr_word(3'd3, 16'hABCD, 2'b11);
        wr_word(3'd3, 16'h1234, 2'b01);
        wr_word(3'd3, 16'hFFFF, 2'b00);
        rd_word(3'd3);
        idle(1);

        // Read-first on same-address write+read.
        wr_word(3'd5, 16'h5555, 2'b11);
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 16'h00FF, 2'b11);
        rd_word(3'd5);
        idle(1);

        // clr with wr/rd the same cycle, then a write on the 3rd busy cycle.
        wr_word(3'd2, 16'h0007, 2'b11);
        step(1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 16'hAAAA, 2'b11);
        idle(2);
        step(1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 16'hFFFF, 2'b11);
        idle(DEPTH);
        rd_word(3'd2);
        rd_word(3'd5);
        idle(1);

        // Reset during the 4th clear cycle restarts the walk.
        wr_word(3'd4, 16'h4444, 2'b11);
        step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0, '0);
        idle(3);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        idle(DEPTH + 1);
        rd_word(3'd4);

        // Out-of-range write ignored, out-of-range read returns zero.
        for (int i = 0; i < DEPTH; i++) wr_word(AW'(i), 16'h1111 * DW'(i + 1), 2'b11);
        wr_word(3'd7, 16'h9999, 2'b11);
        wr_word(3'd6, 16'h8888, 2'b11);
        rd_word(3'd7);
        for (int i = 0; i < DEPTH; i++) rd_word(AW'(i));
        idle(1);

        // Random traffic with occasional clr and reset.
        for (int i = 0; i < 600; i++) begin
            logic r_n, w, r, c;
            r_n = ($urandom_range(0, 249) != 0);
            c   = ($urandom_range(0, 39) == 0);
            w   = $urandom_range(0, 1) != 0;
            r   = $urandom_range(0, 1) != 0;
            step(r_n, w, r, c, AW'($urandom_range(0, 7)), DW'($urandom), NB'($urandom));
        end
        idle(DEPTH + 2);
        for (int i = 0; i < DEPTH; i++) rd_word(AW'(i));
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
